// File: rtl/regfile_param.sv
// Parametrised register file: 1 write port, 2 registered read ports, optional hardwired-zero entry 0.
// Optional same-cycle write-through forwarding to the read ports when REGFILE_BYPASS_EN is defined.
module regfile_param #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_a,
    output logic [WIDTH-1:0]  rdata_b
);

    logic [WIDTH-1:0] entry [DEPTH];
    logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
    logic [WIDTH-1:0] rdata_b_q, rdata_b_d;

    // Each entry is an independent enable/reset word register; entry 0 is a constant when ZERO_REG=1.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        if (ZERO_REG != 0 && i == 0) begin : g_zero
            assign entry[i] = '0;
        end else begin : g_word
            logic [WIDTH-1:0] word_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    word_q <= '0;
                end else if (we && waddr == ADDR_W'(i)) begin
                    word_q <= wdata;
                end
            end
            assign entry[i] = word_q;
        end
    end

    always_comb begin
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        if (re) begin
            rdata_a_d = entry[raddr_a];
            rdata_b_d = entry[raddr_b];
`ifdef REGFILE_BYPASS_EN
            // Forwarding never overrides the hardwired zero entry.
            if (we && waddr == raddr_a && !(ZERO_REG != 0 && raddr_a == '0)) begin
                rdata_a_d = wdata;
            end
            if (we && waddr == raddr_b && !(ZERO_REG != 0 && raddr_b == '0)) begin
                rdata_b_d = wdata;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
        end
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: ZERO_REG=1 and ZERO_REG=0 32-bit instances share stimulus,
// plus an 8-bit x 4-entry instance; expected read data is queued at drive time and popped after the edge.
module tb_regfile_param;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] a0;
        logic [31:0] b0;
        logic [31:0] a1;
        logic [31:0] b1;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        re = 1'b0;
    logic [4:0]  raddr_a = '0;
    logic [4:0]  raddr_b = '0;
    logic [31:0] rdata_a0, rdata_b0, rdata_a1, rdata_b1;

    logic        s_reset = 1'b1;
    logic        s_we = 1'b0;
    logic [1:0]  s_waddr = '0;
    logic [7:0]  s_wdata = '0;
    logic        s_re = 1'b0;
    logic [1:0]  s_raddr_a = '0;
    logic [1:0]  s_raddr_b = '0;
    logic [7:0]  s_rdata_a, s_rdata_b;

    int tests = 0;
    int fails = 0;

    logic [31:0] mdl0 [32];
    logic [31:0] mdl1 [32];
    exp_t        cur;
    exp_t        sb [$];
    logic [15:0] ssb [$];

    always #5 clk = ~clk;

    regfile_param #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1)) dut0 (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a0), .rdata_b(rdata_b0)
    );

    regfile_param #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(0)) dut1 (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a1), .rdata_b(rdata_b1)
    );

    regfile_param #(.WIDTH(8), .DEPTH(4), .ADDR_W(2), .ZERO_REG(1)) dut_s (
        .clk(clk), .reset(s_reset), .we(s_we), .waddr(s_waddr), .wdata(s_wdata), .re(s_re),
        .raddr_a(s_raddr_a), .raddr_b(s_raddr_b), .rdata_a(s_rdata_a), .rdata_b(s_rdata_b)
    );

    // Drive one cycle on both 32-bit instances; expectations are computed from pre-edge model state.
    task automatic step(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic rd, input logic [4:0] ra, input logic [4:0] rb);
        exp_t e;
        @(negedge clk);
        reset = r; we = w; waddr = wa; wdata = wd; re = rd; raddr_a = ra; raddr_b = rb;
        e = cur;
        if (r) begin
            e = '0;
            for (int i = 0; i < 32; i++) begin
                mdl0[i] = '0;
                mdl1[i] = '0;
            end
        end else begin
            if (rd) begin
                e.a0 = (ra == 5'd0) ? 32'h0 : ((BYP && w && wa == ra) ? wd : mdl0[ra]);
                e.b0 = (rb == 5'd0) ? 32'h0 : ((BYP && w && wa == rb) ? wd : mdl0[rb]);
                e.a1 = (BYP && w && wa == ra) ? wd : mdl1[ra];
                e.b1 = (BYP && w && wa == rb) ? wd : mdl1[rb];
            end
            if (w) begin
                if (wa != 5'd0) mdl0[wa] = wd;
                mdl1[wa] = wd;
            end
        end
        cur = e;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        exp_t e;
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
        e = sb.pop_front(); tests++;
        if ({rdata_a0, rdata_b0, rdata_a1, rdata_b1} !== e) begin
            fails++; $display("FAIL reset_state got=%h exp=%h", {rdata_a0, rdata_b0, rdata_a1, rdata_b1}, e);
        end
        step(1'b0, 1'b1, 5'd5, 32'h2D, 1'b0, 5'd0, 5'd0); void'(sb.pop_front());
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5);
        e = sb.pop_front(); tests++;
        if ({rdata_a0, rdata_b0, rdata_a1, rdata_b1} !== e || rdata_a0 !== 32'h2D) begin
            fails++; $display("FAIL preload_5 got=%h exp=%h", {rdata_a0, rdata_b0, rdata_a1, rdata_b1}, e);
        end
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0); void'(sb.pop_front());
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5);
        e = sb.pop_front(); tests++;
        if ({rdata_a0, rdata_b0, rdata_a1, rdata_b1} !== e || rdata_a0 !== 32'h0) begin
            fails++; $display("FAIL reset_clears got=%h exp=%h", {rdata_a0, rdata_b0, rdata_a1, rdata_b1}, e);
        end
    endtask

    task automatic test_write_read;
        exp_t e;
        step(1'b0, 1'b1, 5'd3, 32'h43, 1'b0, 5'd0, 5'd0); void'(sb.pop_front());
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd31);
        e = sb.pop_front(); tests++;
        if ({rdata_a0, rdata_b0, rdata_a1, rdata_b1} !== e || rdata_a0 !== 32'h43) begin
            fails++; $display("FAIL write_read got=%h exp=%h", {rdata_a0, rdata_b0, rdata_a1, rdata_b1}, e);
        end
        step(1'b0, 1'b1, 5'd31, 32'hCAFE_F00D, 1'b0, 5'd0, 5'd0); void'(sb.pop_front());
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 5'd3);
        e = sb.pop_front(); tests++;
        if ({rdata_a0, rdata_b0, rdata_a1, rdata_b1} !== e) begin
            fails++; $display("FAIL top_entry got=%h exp=%h", {rdata_a0, rdata_b0, rdata_a1, rdata_b1}, e);
        end
    endtask

    task automatic test_hold;
        exp_t e;
        step(1'b0, 1'b0, 5'd3, 32'h62, 1'b0, 5'd0, 5'd0); void'(sb.pop_front());
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3);
        e = sb.pop_front(); tests++;
        if ({rdata_a0, rdata_b0, rdata_a1, rdata_b1} !== e || rdata_b0 !== 32'h43) begin
            fails++; $display("FAIL we0_no_write got=%h exp=%h", {rdata_a0, rdata_b0, rdata_a1, rdata_b1}, e);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 5'd4, 32'h1234 + k, 1'b0, 5'd4, 5'd4);
            e = sb.pop_front(); tests++;
            if ({rdata_a0, rdata_b0, rdata_a1, rdata_b1} !== e || rdata_a0 !== 32'h43) begin
                fails++; $display("FAIL re0_hold got=%h exp=%h", {rdata_a0, rdata_b0, rdata_a1, rdata_b1}, e);
            end
        end
    endtask

    task automatic test_zero_reg;
        exp_t e;
        step(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 5'd0); void'(sb.pop_front());
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);
        e = sb.pop_front(); tests++;
        if ({rdata_a0, rdata_b0, rdata_a1, rdata_b1} !== e || rdata_a0 !== 32'h0 || rdata_a1 !== 32'hFFFF_FFFF) begin
            fails++; $display("FAIL zero_reg got=%h exp=%h", {rdata_a0, rdata_b0, rdata_a1, rdata_b1}, e);
        end
        step(1'b0, 1'b1, 5'd0, 32'hA5A5_A5A5, 1'b1, 5'd0, 5'd0);
        e = sb.pop_front(); tests++;
        if ({rdata_a0, rdata_b0, rdata_a1, rdata_b1} !== e || rdata_a0 !== 32'h0) begin
            fails++; $display("FAIL zero_collide got=%h exp=%h", {rdata_a0, rdata_b0, rdata_a1, rdata_b1}, e);
        end
    endtask

    task automatic test_collision;
        exp_t e;
        step(1'b0, 1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 5'd0); void'(sb.pop_front());
        step(1'b0, 1'b1, 5'd7, 32'h22, 1'b1, 5'd7, 5'd7);
        e = sb.pop_front(); tests++;
        if ({rdata_a0, rdata_b0, rdata_a1, rdata_b1} !== e || rdata_a0 !== (BYP ? 32'h22 : 32'h11)) begin
            fails++; $display("FAIL collision got=%h exp=%h", {rdata_a0, rdata_b0, rdata_a1, rdata_b1}, e);
        end
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7);
        e = sb.pop_front(); tests++;
        if ({rdata_a0, rdata_b0, rdata_a1, rdata_b1} !== e || rdata_b0 !== 32'h22) begin
            fails++; $display("FAIL collision_after got=%h exp=%h", {rdata_a0, rdata_b0, rdata_a1, rdata_b1}, e);
        end
    endtask

    task automatic test_reset_vs_write;
        exp_t e;
        step(1'b1, 1'b1, 5'd9, 32'h62, 1'b1, 5'd9, 5'd9); void'(sb.pop_front());
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd7);
        e = sb.pop_front(); tests++;
        if ({rdata_a0, rdata_b0, rdata_a1, rdata_b1} !== e || rdata_a0 !== 32'h0) begin
            fails++; $display("FAIL reset_vs_write got=%h exp=%h", {rdata_a0, rdata_b0, rdata_a1, rdata_b1}, e);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        for (int k = 0; k < 60; k++) begin
            step(($urandom_range(0, 29) == 0), $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            e = sb.pop_front(); tests++;
            if ({rdata_a0, rdata_b0, rdata_a1, rdata_b1} !== e) begin
                fails++; $display("FAIL b2b[%0d] got=%h exp=%h", k, {rdata_a0, rdata_b0, rdata_a1, rdata_b1}, e);
            end
        end
    endtask

    task automatic s_step(input logic r, input logic w, input logic [1:0] wa, input logic [7:0] wd,
                          input logic rd, input logic [1:0] ra, input logic [1:0] rb, input logic [15:0] exp_ab);
        @(negedge clk);
        s_reset = r; s_we = w; s_waddr = wa; s_wdata = wd; s_re = rd; s_raddr_a = ra; s_raddr_b = rb;
        ssb.push_back(exp_ab);
        @(posedge clk);
        #1;
    endtask

    task automatic test_small;
        logic [15:0] e;
        s_step(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 16'h0000);
        e = ssb.pop_front(); tests++;
        if ({s_rdata_a, s_rdata_b} !== e) begin
            fails++; $display("FAIL small_reset got=%h exp=%h", {s_rdata_a, s_rdata_b}, e);
        end
        s_step(1'b0, 1'b1, 2'd3, 8'hA5, 1'b0, 2'd0, 2'd0, 16'h0000); void'(ssb.pop_front());
        s_step(1'b0, 1'b1, 2'd0, 8'hFF, 1'b1, 2'd3, 2'd2, 16'hA500);
        e = ssb.pop_front(); tests++;
        if ({s_rdata_a, s_rdata_b} !== e) begin
            fails++; $display("FAIL small_write_read got=%h exp=%h", {s_rdata_a, s_rdata_b}, e);
        end
        s_step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'd3, 16'h00A5);
        e = ssb.pop_front(); tests++;
        if ({s_rdata_a, s_rdata_b} !== e) begin
            fails++; $display("FAIL small_zero got=%h exp=%h", {s_rdata_a, s_rdata_b}, e);
        end
    endtask

    initial begin
        cur = '0;
        for (int i = 0; i < 32; i++) begin
            mdl0[i] = '0;
            mdl1[i] = '0;
        end
        test_reset;
        test_write_read;
        test_hold;
        test_zero_reg;
        test_collision;
        test_reset_vs_write;
        test_back_to_back;
        test_small;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
